// File: rtl/eth_tx_frame_arbiter.sv
// Frame-level round-robin arbiter in front of the tx client FIFO write port.
// Whole frames are forwarded per grant; frames longer than MAX_LEN are cut and the rest is drained.
module eth_tx_frame_arbiter #(
    parameter int unsigned NUM_SRC    = 2,
    parameter int unsigned MAX_LEN    = 1518,
    parameter int unsigned GAP_CYCLES = 1
) (
    input  logic                 tx_fifo_aclk,
    input  logic                 tx_fifo_resetn,
    input  logic [8*NUM_SRC-1:0] s_axis_tdata,
    input  logic [NUM_SRC-1:0]   s_axis_tvalid,
    input  logic [NUM_SRC-1:0]   s_axis_tlast,
    output logic [NUM_SRC-1:0]   s_axis_tready,
    output logic [7:0]           m_axis_tdata,
    output logic                 m_axis_tvalid,
    output logic                 m_axis_tlast,
    input  logic                 m_axis_tready,
    output logic [NUM_SRC-1:0]   grant,
    output logic                 trunc_err,
    output logic                 busy
);
    localparam int unsigned IDX_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    localparam int unsigned CNT_W = 16;
    localparam int unsigned GAP_W = 4;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_LEN - 32'd1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES == 0) ? 32'd0 : GAP_CYCLES - 32'd1);

    typedef enum logic [1:0] {IDLE, PASS, DRAIN, GAP} state_t;

    state_t             state, state_nxt;
    logic [IDX_W-1:0]   ptr, ptr_nxt;
    logic [IDX_W-1:0]   gidx, gidx_nxt;
    logic [NUM_SRC-1:0] grant_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic [GAP_W-1:0]   gap_cnt, gap_cnt_nxt;
    logic               trunc_nxt;
    logic               found;
    logic [IDX_W-1:0]   win, cand;
    logic [7:0]         sel_data;
    logic               sel_valid, sel_last;
    logic               at_limit;

    // Round-robin search: first requester strictly after the pointer, wrapping.
    always_comb begin
        found = 1'b0;
        win   = ptr;
        cand  = ptr;
        for (int unsigned k = 1; k <= NUM_SRC; k++) begin
            cand = IDX_W'((32'(ptr) + k) % NUM_SRC);
            if (!found && s_axis_tvalid[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end

    // Granted source mux.
    always_comb begin
        sel_data  = '0;
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            if (gidx == IDX_W'(i)) begin
                sel_data  = s_axis_tdata[8*i +: 8];
                sel_valid = s_axis_tvalid[i];
                sel_last  = s_axis_tlast[i];
            end
        end
    end

    assign at_limit = (cnt == LAST_CNT);

    always_comb begin
        state_nxt     = state;
        ptr_nxt       = ptr;
        gidx_nxt      = gidx;
        grant_nxt     = grant;
        cnt_nxt       = cnt;
        gap_cnt_nxt   = gap_cnt;
        trunc_nxt     = 1'b0;
        s_axis_tready = '0;
        m_axis_tdata  = '0;
        m_axis_tvalid = 1'b0;
        m_axis_tlast  = 1'b0;
        unique case (state)
            IDLE: begin
                if (found) begin
                    state_nxt = PASS;
                    ptr_nxt   = win;
                    gidx_nxt  = win;
                    grant_nxt = NUM_SRC'(1) << win;
                    cnt_nxt   = '0;
                end
            end
            PASS: begin
                m_axis_tdata        = sel_data;
                m_axis_tvalid       = sel_valid;
                m_axis_tlast        = sel_last | at_limit;
                s_axis_tready[gidx] = m_axis_tready;
                if (sel_valid && m_axis_tready) begin
                    cnt_nxt = cnt + CNT_W'(1);
                    if (sel_last) begin
                        state_nxt   = GAP;
                        grant_nxt   = '0;
                        gap_cnt_nxt = '0;
                    end else if (at_limit) begin
                        // Forced tlast already went out on this beat; discard the remainder.
                        state_nxt = DRAIN;
                        trunc_nxt = 1'b1;
                    end
                end
            end
            DRAIN: begin
                s_axis_tready[gidx] = 1'b1;
                if (sel_valid && sel_last) begin
                    state_nxt   = GAP;
                    grant_nxt   = '0;
                    gap_cnt_nxt = '0;
                end
            end
            GAP: begin
                if (gap_cnt == GAP_LAST) begin
                    state_nxt = IDLE;
                end else begin
                    gap_cnt_nxt = gap_cnt + GAP_W'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge tx_fifo_aclk or negedge tx_fifo_resetn) begin
        if (!tx_fifo_resetn) begin
            state     <= IDLE;
            ptr       <= IDX_W'(NUM_SRC - 32'd1);
            gidx      <= '0;
            grant     <= '0;
            cnt       <= '0;
            gap_cnt   <= '0;
            trunc_err <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_nxt;
            ptr       <= ptr_nxt;
            gidx      <= gidx_nxt;
            grant     <= grant_nxt;
            cnt       <= cnt_nxt;
            gap_cnt   <= gap_cnt_nxt;
            trunc_err <= trunc_nxt;
            busy      <= (state_nxt != IDLE);
        end
    end
endmodule
